vend_coin_sched: RTL and testbench
==================================

Name: vend_coin_sched

Overview:
- Controller that sits in front of the vending-machine core and feeds it coins.
- Arbitrates coin-insert requests from NUM_SLOTS coin acceptors (round-robin) and buffers accepted coins in a small FIFO.
- Drives the core's two_in/one_in as clean, mutually exclusive single-cycle pulses with enforced spacing.
- Monitors choco_out/chng_out to pause feeding while the core dispenses and self-resets.

Parameters:
- NUM_SLOTS, 2, number of coin-acceptor requesters (2..8).
- QDEPTH, 4, coin FIFO depth; power of two, 2..16.
- HOLD_CYC, 2, idle cycles held after a detected vend before the next coin is driven (1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately.
- coin_req  input  NUM_SLOTS  per-slot request; held high until acked.
- coin_val  input  NUM_SLOTS  per-slot coin value, stable while req is high (0 = one-rupee, 1 = two-rupee).
- coin_ack  output  NUM_SLOTS  one-hot, 1-cycle acceptance pulse.
- one_in  output  1  one-rupee pulse to core.
- two_in  output  1  two-rupee pulse to core.
- choco_out  input  1  core dispense indication.
- chng_out  input  1  core change indication.
- vend_pulse  output  1  1-cycle pulse per detected dispense.
- chng_pulse  output  1  1-cycle pulse per detected change return.
- q_count  output  $clog2(QDEPTH)+1  FIFO occupancy.
- busy  output  1  high when the FIFO is non-empty or FSM != IDLE.

Behaviour:
- Reset values: all outputs 0; FIFO empty; RR pointer = NUM_SLOTS-1 (slot 0 has first priority); FSM = IDLE.
- Reset mid-operation: queued coins are discarded and no ack is issued for pending requests; slots keep req high and are re-arbitrated after reset.
- Arbitration, evaluated every cycle:
  - Grant exists when any coin_req is high and the registered q_count < QDEPTH. A same-cycle pop does not free space.
  - Search starts at pointer+1 and wraps modulo NUM_SLOTS. The pointer updates to the granted slot only when a grant occurs.
  - Grant at edge E0: coin_ack[slot] is high for cycle E0..E1, and coin_val[slot] is written to the FIFO at E0.
  - A requester must drop req after seeing ack. Req still high in the cycle after ack counts as a new coin.
- FIFO: circular, wrap-around pointers. Push and pop in the same cycle are both allowed, and occupancy is unchanged. A push is never attempted when full; a pop is never attempted when empty.
- FSM (registered outputs):
  - IDLE: if q_count > 0, pop at the next edge, assert exactly one of one_in/two_in per popped value, then go to DRIVE.
  - DRIVE: pulse high for exactly 1 cycle, then SETTLE.
  - SETTLE (1 cycle): sample choco_out/chng_out.
    - choco_out = 1: vend_pulse = 1 next cycle; chng_pulse = chng_out; go to HOLD.
    - Otherwise: go to IDLE.
  - HOLD: count HOLD_CYC cycles, then go to IDLE.
- Latency:
  - Empty system: req seen at E0 → ack E0..E1 → coin pulse E1..E2.
  - Minimum coin-to-coin spacing is 3 cycles (DRIVE, SETTLE, IDLE-pop), or 3+HOLD_CYC after a vend.
- Invariant: one_in & two_in is never 1.

Optional Feature:
- Macro: VEND_SCHED_STATS_EN.
- When defined, adds three outputs:
  - vend_cnt[15:0]: increments on vend_pulse.
  - chng_cnt[15:0]: increments on chng_pulse.
  - drop_cnt[7:0]: increments each cycle a req is pending while the FIFO is full.
  - All counters saturate rather than wrap and reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package vend_pkg holds:
  - coin encoding constants COIN_ONE = 1'b0 and COIN_TWO = 1'b1;
  - FSM state encoding IDLE/DRIVE/SETTLE/HOLD, 2 bits;
  - the default HOLD_CYC constant.
- Sub-module vend_coin_fifo: parameterised QDEPTH × 1-bit circular FIFO with push, pop, count, full and empty.
- The arbiter and FSM stay in the top module.

Test Plan:
- Reset, then slot0 req with val=1 at E0 → coin_ack=01 at E0..E1, two_in high E1..E2, one_in never high, q_count returns to 0.
- Slots 0 and 1 both hold req continuously (vals 0 and 1) → acks alternate 01, 10, 01, 10 until full; FIFO order matches the grant order.
- Six coins back-to-back from slot0 with QDEPTH=4 → acks stop at q_count=4 and resume the cycle after the first pop; all 6 coins are driven in order.
- Core model asserts choco_out during SETTLE → vend_pulse for 1 cycle, then no coin pulse for HOLD_CYC=2 cycles; with chng_out=1, chng_pulse is also 1.
- reset low asynchronously mid-DRIVE with 3 coins queued → one_in/two_in drop immediately, q_count=0, no ack for the pending req until after reset rises.
- VEND_SCHED_STATS_EN defined, 3 vends and 1 change → vend_cnt=3, chng_cnt=1; FIFO held full for 5 cycles with a pending req → drop_cnt=5.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared constants for the vending coin scheduler: coin encoding, FSM states,
// and the default post-vend hold length.
package vend_pkg;

    localparam logic COIN_ONE = 1'b0;
    localparam logic COIN_TWO = 1'b1;

    localparam int HOLD_CYC_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/vend_coin_fifo.sv
// QDEPTH x 1-bit circular coin FIFO. Depth is a power of two, so the read and
// write pointers wrap on their own. The caller never pushes when the FIFO is
// full and never pops when it is empty.
module vend_coin_fifo #(
    parameter int QDEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    din_i,
    input  logic                    pop_i,
    output logic                    dout_o,
    output logic [$clog2(QDEPTH):0] count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [QDEPTH-1:0] mem_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    // Storage and pointers; a simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(QDEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vend_coin_sched.sv
// Coin scheduler in front of the vending core: round-robin arbitration over
// the coin acceptors, a coin FIFO, and an FSM that emits spaced, mutually
// exclusive one_in/two_in pulses and pauses after each detected vend.
// Optional statistics counters are built when VEND_SCHED_STATS_EN is defined.
module vend_coin_sched
    import vend_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int QDEPTH    = 4,
    parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SLOTS-1:0]    coin_req,
    input  logic [NUM_SLOTS-1:0]    coin_val,
    output logic [NUM_SLOTS-1:0]    coin_ack,
    output logic                    one_in,
    output logic                    two_in,
    input  logic                    choco_out,
    input  logic                    chng_out,
    output logic                    vend_pulse,
    output logic                    chng_pulse,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic                    busy
`ifdef VEND_SCHED_STATS_EN
    ,
    output logic [15:0]             vend_cnt,
    output logic [15:0]             chng_cnt,
    output logic [7:0]              drop_cnt
`endif
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [SW-1:0]        rr_q, gnt_idx;
    logic                 gnt_vld, push, pop;
    logic [NUM_SLOTS-1:0] ack_q, ack_d;
    logic                 fifo_dout, fifo_full, fifo_empty;
    state_e               state_q;
    logic [2:0]           hold_q;
    logic                 one_q, two_q, vend_q, chng_q;

    vend_coin_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (coin_val[gnt_idx]),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (q_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Round-robin search starting one past the last granted slot
    always_comb begin
        logic [SW-1:0] cand;
        cand    = '0;
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            cand = SW'((int'(rr_q) + i) % NUM_SLOTS);
            if (!gnt_vld && coin_req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Occupancy is the registered count, so a pop in the same cycle does not make room
    assign push = gnt_vld && !fifo_full;
    assign pop  = (state_q == IDLE) && !fifo_empty;

    // One-hot acceptance for the granted slot
    always_comb begin
        ack_d = '0;
        if (push) ack_d[gnt_idx] = 1'b1;
    end

    // Ack register and round-robin pointer (pointer moves only on a grant)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q <= '0;
            rr_q  <= SW'(NUM_SLOTS - 1);
        end else begin
            ack_q <= ack_d;
            if (push) rr_q <= gnt_idx;
        end
    end

    // Feed FSM: pop -> 1-cycle pulse -> settle/sample core -> optional hold after a vend
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            one_q   <= 1'b0;
            two_q   <= 1'b0;
            vend_q  <= 1'b0;
            chng_q  <= 1'b0;
        end else begin
            one_q  <= 1'b0;
            two_q  <= 1'b0;
            vend_q <= 1'b0;
            chng_q <= 1'b0;
            case (state_q)
                IDLE: if (!fifo_empty) begin
                    one_q   <= (fifo_dout == COIN_ONE);
                    two_q   <= (fifo_dout == COIN_TWO);
                    state_q <= DRIVE;
                end
                DRIVE: state_q <= SETTLE;
                SETTLE: if (choco_out) begin
                    vend_q  <= 1'b1;
                    chng_q  <= chng_out;
                    hold_q  <= '0;
                    state_q <= HOLD;
                end else begin
                    state_q <= IDLE;
                end
                HOLD: if (hold_q == 3'(HOLD_CYC - 1)) state_q <= IDLE;
                      else hold_q <= hold_q + 3'd1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coin_ack   = ack_q;
    assign one_in     = one_q;
    assign two_in     = two_q;
    assign vend_pulse = vend_q;
    assign chng_pulse = chng_q;
    assign busy       = !fifo_empty || (state_q != IDLE);

`ifdef VEND_SCHED_STATS_EN
    logic [15:0] vend_cnt_q, chng_cnt_q;
    logic [7:0]  drop_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vend_cnt_q <= '0;
            chng_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (vend_q && vend_cnt_q != 16'hFFFF) vend_cnt_q <= vend_cnt_q + 16'd1;
            if (chng_q && chng_cnt_q != 16'hFFFF) chng_cnt_q <= chng_cnt_q + 16'd1;
            if ((|coin_req) && fifo_full && drop_cnt_q != 8'hFF)
                drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign vend_cnt = vend_cnt_q;
    assign chng_cnt = chng_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vend_coin_sched.sv
// Randomized bench for vend_coin_sched. The reference model keeps the coin
// queue as a SV queue and tracks feed timing as "earliest next pop cycle"
// arithmetic; every output is compared each cycle.
module tb_vend_coin_sched;

    localparam int NS = 3;
    localparam int QD = 4;
    localparam int HC = 2;
    localparam int CW = $clog2(QD) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] coin_req, coin_val, coin_ack;
    logic          one_in, two_in, choco_out, chng_out, vend_pulse, chng_pulse, busy;
    logic [CW-1:0] q_count;
`ifdef VEND_SCHED_STATS_EN
    logic [15:0]   vend_cnt, chng_cnt;
    logic [7:0]    drop_cnt;
`endif

    vend_coin_sched #(.NUM_SLOTS(NS), .QDEPTH(QD), .HOLD_CYC(HC)) dut (
        .clk        (clk),
        .reset      (reset),
        .coin_req   (coin_req),
        .coin_val   (coin_val),
        .coin_ack   (coin_ack),
        .one_in     (one_in),
        .two_in     (two_in),
        .choco_out  (choco_out),
        .chng_out   (chng_out),
        .vend_pulse (vend_pulse),
        .chng_pulse (chng_pulse),
        .q_count    (q_count),
        .busy       (busy)
`ifdef VEND_SCHED_STATS_EN
        ,
        .vend_cnt   (vend_cnt),
        .chng_cnt   (chng_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Environment: coins waiting at each acceptor, core-response mode
    bit pend[NS][$];
    int choco_mode = 0;   // 0: never dispense, 1: random, 2: always

    // Reference model state
    bit          mq[$];
    int          rr, cyc, next_ok, settle_at;
    logic [NS-1:0] e_ack;
    bit          e_one, e_two, e_vend, e_chng, e_busy;
    int          e_vc, e_cc, e_dc;

    task automatic model_reset();
        mq.delete();
        rr = NS - 1; next_ok = 0; settle_at = -1;
        e_ack = '0; e_one = 0; e_two = 0; e_vend = 0; e_chng = 0; e_busy = 0;
        e_vc = 0; e_cc = 0; e_dc = 0;
    endtask

    // One clock edge of the reference behaviour, using inputs present at the edge
    task automatic model_edge();
        int qsz;
        int g;
        bit v;
        qsz = mq.size();
        g = -1;
        if (e_vend) e_vc++;
        if (e_chng) e_cc++;
        if (coin_req != '0 && qsz == QD && e_dc < 255) e_dc++;
        e_vend = (settle_at == cyc) && choco_out;
        e_chng = e_vend && chng_out;
        if (e_vend) next_ok = cyc + 1 + HC;
        e_one = 0; e_two = 0;
        if (cyc >= next_ok && qsz > 0) begin
            v = mq.pop_front();
            e_one = (v == 1'b0);
            e_two = (v == 1'b1);
            next_ok = cyc + 3;
            settle_at = cyc + 2;
        end
        e_ack = '0;
        if (coin_req != '0 && qsz < QD) begin
            for (int i = 1; i <= NS; i++) begin
                int s;
                s = (rr + i) % NS;
                if (g < 0 && coin_req[s]) g = s;
            end
        end
        if (g >= 0) begin
            e_ack[g] = 1'b1;
            rr = g;
            mq.push_back(coin_val[g]);
        end
        e_busy = (mq.size() > 0) || (cyc + 1 < next_ok);
        cyc++;
    endtask

    task automatic compare_all();
        chk("coin_ack", coin_ack, e_ack);
        chk("one_in", one_in, e_one);
        chk("two_in", two_in, e_two);
        chk("one_two_excl", one_in & two_in, 0);
        chk("vend_pulse", vend_pulse, e_vend);
        chk("chng_pulse", chng_pulse, e_chng);
        chk("q_count", q_count, mq.size());
        chk("busy", busy, e_busy);
`ifdef VEND_SCHED_STATS_EN
        chk("vend_cnt", vend_cnt, e_vc);
        chk("chng_cnt", chng_cnt, e_cc);
        chk("drop_cnt", drop_cnt, e_dc);
`endif
    endtask

    task automatic drive_inputs();
        for (int s = 0; s < NS; s++) begin
            coin_req[s] = pend[s].size() > 0;
            coin_val[s] = (pend[s].size() > 0) ? pend[s][0] : 1'b0;
        end
        case (choco_mode)
            1:       choco_out = ($urandom_range(0, 2) == 0);
            2:       choco_out = 1'b1;
            default: choco_out = 1'b0;
        endcase
        chng_out = (choco_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    // One cycle: model at the edge, compare 1 time unit later, then react
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        for (int s = 0; s < NS; s++)
            if (coin_ack[s] && pend[s].size() > 0) void'(pend[s].pop_front());
        drive_inputs();
    endtask

    function automatic bit env_idle();
        bit idle;
        idle = (mq.size() == 0) && !e_busy;
        for (int s = 0; s < NS; s++) if (pend[s].size() > 0) idle = 0;
        return idle;
    endfunction

    task automatic run_until_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!env_idle() && n < max_cyc);
        chk(tag, n < max_cyc, 1);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        coin_req = '0; coin_val = '0; choco_out = 1'b0; chng_out = 1'b0;
        model_reset();
        cyc = 0;
        #1;
        chk("rst_ack", coin_ack, 0);
        chk("rst_one", one_in, 0);
        chk("rst_two", two_in, 0);
        chk("rst_qcnt", q_count, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Single two-rupee coin from slot 0
        choco_mode = 0;
        pend[0].push_back(1'b1);
        drive_inputs();
        run_until_idle("drain_single", 40);

        // Slots 0 and 1 both requesting continuously
        for (int k = 0; k < 6; k++) begin
            pend[0].push_back(1'b0);
            pend[1].push_back(1'b1);
        end
        drive_inputs();
        run_until_idle("drain_two_slots", 200);

        // Six back-to-back coins from one slot overflow the queue
        for (int k = 0; k < 6; k++) pend[0].push_back(1'($urandom_range(0, 1)));
        drive_inputs();
        run_until_idle("drain_six", 200);

        // Core dispenses and returns change on every coin
        choco_mode = 2;
        pend[1].push_back(1'b0); pend[1].push_back(1'b1); pend[2].push_back(1'b1);
        drive_inputs();
        run_until_idle("drain_vend", 200);

        // Random traffic with random dispense / change responses
        choco_mode = 1;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int s;
                s = $urandom_range(0, NS - 1);
                if (pend[s].size() < 3) pend[s].push_back(1'($urandom_range(0, 1)));
            end
            step();
        end
        run_until_idle("drain_random", 400);

        // Asynchronous reset while a coin pulse is on the wire with coins queued
        choco_mode = 0;
        for (int k = 0; k < 6; k++) pend[0].push_back(1'($urandom_range(0, 1)));
        drive_inputs();
        n = 0;
        do begin
            step();
            n++;
        end while (!((one_in || two_in) && q_count == CW'(3)) && n < 40);
        chk("reach_drive_q3", n < 40, 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_one", one_in, 0);
        chk("arst_two", two_in, 0);
        chk("arst_qcnt", q_count, 0);
        chk("arst_ack", coin_ack, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        chk("arst_req_pending", coin_req != '0, 1);
        chk("arst_no_ack", coin_ack, 0);
        @(negedge clk) reset = 1'b1;
        run_until_idle("drain_after_reset", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
